// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch buffer.
// Holds the NOP encoding, default geometry, the PC step and the queue entry record.
package fetch_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue with push, pop and a synchronous clear.
// The read port is combinational, so the head entry is visible as soon as it is written.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int               AW         = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full queue refuses the push even if the head leaves in the same cycle.
    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: PC register, redirect priority and a small queue towards decode.
// A redirect flushes the queue and reloads the PC; otherwise fetches push while there is room.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PCSrc,
    input  logic                   PC_write,
    input  logic [XLEN-1:0]        PC_Branch,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [XLEN-1:0]        PC_ID,
    output logic [XLEN-1:0]        INSTRUCTION_ID,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);
    localparam logic [XLEN-1:0] NOP     = XLEN'(NOP_INSTR);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [2*XLEN-1:0] head_entry;

    assign imem_addr = pc_q;

    // Redirect wins over both fetch enable and decode acceptance.
    assign push = PC_write & ~PCSrc & ~fifo_full;
    assign pop  = ~fifo_empty & id_ready & ~PCSrc;

    always_comb begin
        pc_d = pc_q;
        if (PCSrc) begin
            pc_d = PC_Branch;
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (PCSrc),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pc_q, imem_rdata}),
        .rdata_o (head_entry),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign id_valid       = ~fifo_empty;
    assign PC_ID          = fifo_empty ? '0  : head_entry[2*XLEN-1:XLEN];
    assign INSTRUCTION_ID = fifo_empty ? NOP : head_entry[XLEN-1:0];

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter XLEN, 32, width of PC, branch target and instruction words.
REQ-002 Parameter DEPTH, 4, fetch-queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-004 Port clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port PCSrc  in  1  redirect request from the branch unit.
REQ-007 Port PC_write  in  1  fetch enable; 0 = fetch stall.
REQ-008 Port PC_Branch  in  XLEN  redirect target, sampled when PCSrc=1.
REQ-009 Port imem_addr  out  XLEN  instruction memory address, equal to the current PC.
REQ-010 Port imem_rdata  in  XLEN  instruction word for imem_addr, valid in the same cycle (combinational read).
REQ-011 Port id_ready  in  1  decode stage accepts the head entry this cycle (replaces IF_ID_write).
REQ-012 Port id_valid  out  1  head entry present.
REQ-013 Port PC_ID  out  XLEN  PC of the head entry.
REQ-014 Port INSTRUCTION_ID  out  XLEN  instruction of the head entry.
REQ-015 Port count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 The PC register SHALL drive imem_addr directly.
REQ-017 Push condition: PC_write=1, PCSrc=0 and count<DEPTH at the start of the cycle; push writes {PC, imem_rdata} at the write pointer and sets PC to PC+4.
REQ-018 PC+4 SHALL wrap modulo 2^XLEN.
REQ-019 A full queue SHALL block the push and hold the PC, even when a pop occurs in the same cycle (no full-bypass).
REQ-020 Pop condition: id_valid=1, id_ready=1 and PCSrc=0; pop advances the read pointer.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 Count update: count+1 on push only, count-1 on pop only, unchanged on push and pop together.
REQ-023 id_valid SHALL equal (count != 0).
REQ-024 PC_ID and INSTRUCTION_ID SHALL show the head entry combinationally from storage.
REQ-025 When count=0: PC_ID=0 and INSTRUCTION_ID=NOP (32'h0000_0013).
REQ-026 Fetch-to-decode latency: an instruction pushed at edge N into an empty queue SHALL be visible at the outputs from edge N until it is popped (one IF->ID stage, same as a pipeline register).
REQ-027 PCSrc=1 SHALL override PC_write and id_ready.
REQ-028 On a PCSrc=1 edge: PC<=PC_Branch, both pointers<=0, count<=0, no push, no pop.
REQ-029 After a PCSrc=1 edge: id_valid=0 in the next cycle, and the fetch from PC_Branch pushes in that cycle when PC_write=1.
REQ-030 PC_write=0 with PCSrc=0 SHALL hold the PC and block pushes; pops continue.
REQ-031 Storage contents of non-occupied entries SHALL never be visible at the outputs.

Reset
REQ-032 Asserting reset SHALL immediately, without a clock edge, set PC=RESET_PC, pointers=0 and count=0, so that id_valid=0, PC_ID=0 and INSTRUCTION_ID=NOP.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries.
REQ-034 The first push after reset deassertion SHALL fetch RESET_PC.
REQ-035 Storage array contents need not be reset.

Structure
REQ-036 Shared package fetch_pkg SHALL hold: the NOP constant, default XLEN/DEPTH/RESET_PC, the PC increment constant 4, and the entry record {pc, instr}.
REQ-037 Queue storage and pointers SHALL be one sub-module, fetch_fifo (parametrised by width and DEPTH, with push/pop/clear/count).
REQ-038 PC logic and redirect priority SHALL reside in fetch_buffer.

Verification
REQ-039 Fill: reset, PC_write=1, id_ready=0 for 6 cycles, DEPTH=4 -> count=4, PC=0x10 held, head PC_ID=0x0, INSTRUCTION_ID=mem[0].
REQ-040 Streaming: PC_write=1, id_ready=1 continuously -> count stays at 1 after the first push; PC_ID = 0x0, 0x4, 0x8, ... one per cycle.
REQ-041 Full with pop: count=4, id_ready=1, PC_write=1 for one cycle -> count=3, PC unchanged; next cycle push resumes, count=3.
REQ-042 Redirect: count=3, PCSrc=1, PC_Branch=0x100, id_ready=1 -> next cycle count=0, id_valid=0, imem_addr=0x100; following cycle PC_ID=0x100.
REQ-043 Async reset mid-run: reset pulsed between edges with count=2 -> id_valid=0 and INSTRUCTION_ID=0x13 before the next edge; PC=RESET_PC.
REQ-044 Wrap-around: RESET_PC=0xFFFF_FFF8, 3 pushes -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pointers wrap after DEPTH pushes/pops with data intact.
